// File: rtl/ppi_pkg.sv
// Shared types and constants for the 8255 port-group controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ppi_pkg;

  localparam int PPI_WIDTH = 8;

  localparam logic MODE0   = 1'b0;
  localparam logic MODE1   = 1'b1;
  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  typedef enum logic [1:0] {
    IN_EMPTY  = 2'd0,
    IN_FULL   = 2'd1,
    OUT_EMPTY = 2'd2,
    OUT_FULL  = 2'd3
  } port_state_e;

  // Idle state a freshly configured port starts from, chosen by direction.
  function automatic port_state_e empty_state(input logic dir);
    return (dir == DIR_IN) ? IN_EMPTY : OUT_EMPTY;
  endfunction

endpackage

// File: rtl/ppi_strobed_port_if.sv
// Bus-side and pin-side signal bundle of one PPI port group.
// Latency: n/a (wiring only).
// Backpressure: n/a; handshakes are the 8255 STB/IBF and OBF/ACK pairs.
interface ppi_strobed_port_if
  import ppi_pkg::*;
#(
  parameter int WIDTH = PPI_WIDTH
) ();

  logic             cfg_wr;
  logic             mode_en;
  logic             dir_in;
  logic             inte;
  logic             cpu_rd;
  logic             cpu_wr;
  logic [WIDTH-1:0] cpu_wdata;
  logic [WIDTH-1:0] cpu_rdata;
  logic [WIDTH-1:0] port_in;
  logic [WIDTH-1:0] port_out;
  logic             port_oe;
  logic             stb_n;
  logic             ibf;
  logic             ack_n;
  logic             obf_n;
  logic             intr;

  // Bus buffer / peripheral side
  modport master (
    output cfg_wr, mode_en, dir_in, inte, cpu_rd, cpu_wr, cpu_wdata,
    output port_in, stb_n, ack_n,
    input  cpu_rdata, port_out, port_oe, ibf, obf_n, intr
  );

  // Port controller side
  modport slave (
    input  cfg_wr, mode_en, dir_in, inte, cpu_rd, cpu_wr, cpu_wdata,
    input  port_in, stb_n, ack_n,
    output cpu_rdata, port_out, port_oe, ibf, obf_n, intr
  );

endinterface

// File: rtl/ppi_edge_sync.sv
// Synchronises an async active-low handshake pin and emits one-cycle rise/fall pulses.
// Latency: SYNC_STAGES+1 clocks from pin edge to pulse (registered pulse output).
// Backpressure: none; every settled pin transition yields exactly one pulse.
module ppi_edge_sync #(
  parameter int SYNC_STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   rise_q;
  logic                   fall_q;

  // Sync chain, edge-history flop and pulse flops; all idle high so reset release is edge-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      last_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      last_q <= sync_q[SYNC_STAGES-1];
      rise_q <= ~last_q & sync_q[SYNC_STAGES-1];
      fall_q <= last_q & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ppi_strobed_port.sv
// 8255 port-group controller: Mode 0 latched I/O, Mode 1 strobed I/O with IBF/OBF and INTR.
// Latency: data and flags update one clock after the bus event; pin strobes add SYNC_STAGES+1.
// Backpressure: none; Mode 1 input overrun overwrites the latch, flags only report buffer state.
module ppi_strobed_port
  import ppi_pkg::*;
#(
  parameter int WIDTH       = PPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst_n,
  ppi_strobed_port_if.slave bus
);

  port_state_e      state_q, state_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] in_q, in_d;     // Mode 0 pin sample / Mode 1 input latch
  logic [WIDTH-1:0] out_q, out_d;   // output latch, read back in output direction
  logic             req_q, req_d;   // interrupt request before the inte gate
  logic             stb_rise, stb_fall;
  logic             ack_rise, ack_fall;

  ppi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(bus.stb_n),
    .rise_o (stb_rise),
    .fall_o (stb_fall)
  );

  ppi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(bus.ack_n),
    .rise_o (ack_rise),
    .fall_o (ack_fall)
  );

  // State register: handshake FSM, latched configuration and data latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IN_EMPTY;
      mode_q  <= MODE0;
      dir_q   <= DIR_IN;
      in_q    <= '0;
      out_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      in_q    <= in_d;
      out_q   <= out_d;
      req_q   <= req_d;
    end
  end

  // Next state: configuration first, then per-mode handshake rules (set beats clear where they meet)
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    in_d    = in_q;
    out_d   = out_q;
    req_d   = req_q;
    if (bus.cfg_wr) begin
      mode_d  = bus.mode_en;
      dir_d   = bus.dir_in;
      out_d   = '0;
      req_d   = 1'b0;
      state_d = empty_state(bus.dir_in);
    end else if (mode_q == MODE0) begin
      if (dir_q == DIR_IN) begin
        in_d = bus.port_in;
      end else if (bus.cpu_wr) begin
        out_d = bus.cpu_wdata;
      end
    end else if (dir_q == DIR_IN) begin
      // Request is recorded regardless of inte so re-enabling can restore intr
      if (stb_rise && state_q == IN_FULL) req_d = 1'b1;
      if (bus.cpu_rd) begin
        req_d   = 1'b0;
        state_d = IN_EMPTY;
      end
      if (stb_fall) begin
        in_d    = bus.port_in;
        state_d = IN_FULL;
      end
    end else begin
      if (ack_fall && state_q == OUT_FULL) state_d = OUT_EMPTY;
      if (ack_rise && state_q == OUT_EMPTY) req_d = 1'b1;
      if (bus.cpu_wr) begin
        out_d   = bus.cpu_wdata;
        req_d   = 1'b0;
        state_d = OUT_FULL;
      end
    end
  end

  // Outputs: flags decoded from the registered state, intr gated live by inte
  always_comb begin
    bus.ibf       = (mode_q == MODE1) && (state_q == IN_FULL);
    bus.obf_n     = !((mode_q == MODE1) && (state_q == OUT_FULL));
    bus.intr      = req_q & bus.inte;
    bus.port_oe   = (dir_q == DIR_OUT);
    bus.port_out  = out_q;
    bus.cpu_rdata = (dir_q == DIR_IN) ? in_q : out_q;
  end

endmodule

// File: tb/tb_ppi_strobed_port.sv
module tb_ppi_strobed_port;
  import ppi_pkg::*;

  localparam int S = 2;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ppi_strobed_port_if #(.WIDTH(8)) bus ();

  ppi_strobed_port #(.WIDTH(8), .SYNC_STAGES(S)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A port holds at most one byte; m_full says whether it is waiting to be read (input)
  // or collected by the peripheral (output). Pin history: h[k] = pin sampled k edges ago.
  bit         m_mode, m_dir, m_full, m_req;
  bit [7:0]   m_in, m_out;
  bit [S+2:0] stb_h, ack_h;

  task automatic model_reset();
    m_mode = 1'b0; m_dir = 1'b1; m_full = 1'b0; m_req = 1'b0;
    m_in = 8'h00; m_out = 8'h00; stb_h = '1; ack_h = '1;
  endtask

  task automatic model_edge();
    bit sf, sr, af, ar;
    stb_h = {stb_h[S+1:0], bus.stb_n};
    ack_h = {ack_h[S+1:0], bus.ack_n};
    // A pin edge is acted on S+1 edges after the first sample showing it
    sf = stb_h[S+2] & ~stb_h[S+1];
    sr = ~stb_h[S+2] & stb_h[S+1];
    af = ack_h[S+2] & ~ack_h[S+1];
    ar = ~ack_h[S+2] & ack_h[S+1];
    if (bus.cfg_wr) begin
      m_mode = bus.mode_en; m_dir = bus.dir_in; m_full = 1'b0; m_req = 1'b0; m_out = 8'h00;
    end else if (!m_mode) begin
      if (m_dir) m_in = bus.port_in;
      else if (bus.cpu_wr) m_out = bus.cpu_wdata;
    end else if (m_dir) begin
      if (sr && m_full) m_req = 1'b1;
      if (bus.cpu_rd) begin m_req = 1'b0; m_full = 1'b0; end
      if (sf) begin m_in = bus.port_in; m_full = 1'b1; end
    end else begin
      if (af) m_full = 1'b0;
      if (ar && !m_full) m_req = 1'b1;
      if (bus.cpu_wr) begin m_out = bus.cpu_wdata; m_req = 1'b0; m_full = 1'b1; end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk1({tag, ".ibf"},      bus.ibf,       m_mode & m_dir & m_full);
    chk1({tag, ".obf_n"},    bus.obf_n,     ~(m_mode & ~m_dir & m_full));
    chk1({tag, ".intr"},     bus.intr,      m_req & bus.inte);
    chk1({tag, ".port_oe"},  bus.port_oe,   ~m_dir);
    chk8({tag, ".port_out"}, bus.port_out,  m_out);
    chk8({tag, ".rdata"},    bus.cpu_rdata, m_dir ? m_in : m_out);
  endtask

  // One clock: model sees the same inputs as the DUT edge, outputs sampled 1ns later
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cfg(input logic mode, input logic dir);
    bus.cfg_wr = 1'b1; bus.mode_en = mode; bus.dir_in = dir;
    cycle();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] val);
    bus.port_in = val; bus.stb_n = 1'b0;
    repeat (6) cycle();
    bus.stb_n = 1'b1;
    repeat (6) cycle();
  endtask

  // ---------------- Mode 0 vector table ----------------
  typedef struct {
    logic       cfg_wr, mode_en, dir_in, cpu_wr;
    logic [7:0] wdata, port_in;
    logic       stb_n;
    logic       e_oe;
    logic [7:0] e_out, e_rdata;
  } vec_t;

  vec_t tv[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.cfg_wr = 1'b0; bus.mode_en = 1'b0; bus.dir_in = 1'b1; bus.inte = 1'b0;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_wdata = 8'h00; bus.port_in = 8'h00;
    bus.stb_n = 1'b1; bus.ack_n = 1'b1;
    model_reset();

    //             cfg mod dir wr  wdata  pin    stb  oe  out    rdata
    tv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00};
    tv[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h00, 1'b1, 1'b1, 8'hA5, 8'hA5};
    tv[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, 8'hA5, 8'hA5};
    tv[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h00, 1'b1, 1'b1, 8'h3C, 8'h3C};
    tv[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00};
    tv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h96, 1'b1, 1'b0, 8'h00, 8'h96};
    tv[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h69, 1'b0, 1'b0, 8'h00, 8'h69};
    tv[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h69, 1'b1, 1'b0, 8'h00, 8'h69};

    // Reset values while held in reset
    #12;
    chk1("rst.ibf", bus.ibf, 1'b0);
    chk1("rst.obf_n", bus.obf_n, 1'b1);
    chk1("rst.intr", bus.intr, 1'b0);
    chk1("rst.port_oe", bus.port_oe, 1'b0);
    chk8("rst.port_out", bus.port_out, 8'h00);
    chk8("rst.rdata", bus.cpu_rdata, 8'h00);
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1;
    cycle();
    cmp_model("post_reset");

    // Mode 0 output and input, handshake pins ignored
    for (int i = 0; i < 8; i++) begin
      bus.cfg_wr = tv[i].cfg_wr; bus.mode_en = tv[i].mode_en; bus.dir_in = tv[i].dir_in;
      bus.cpu_wr = tv[i].cpu_wr; bus.cpu_wdata = tv[i].wdata; bus.port_in = tv[i].port_in;
      bus.stb_n = tv[i].stb_n;
      cycle();
      chk1($sformatf("tv%0d.port_oe", i), bus.port_oe, tv[i].e_oe);
      chk8($sformatf("tv%0d.port_out", i), bus.port_out, tv[i].e_out);
      chk8($sformatf("tv%0d.rdata", i), bus.cpu_rdata, tv[i].e_rdata);
      chk1($sformatf("tv%0d.ibf", i), bus.ibf, 1'b0);
      chk1($sformatf("tv%0d.obf_n", i), bus.obf_n, 1'b1);
      chk1($sformatf("tv%0d.intr", i), bus.intr, 1'b0);
    end
    bus.cfg_wr = 1'b0; bus.cpu_wr = 1'b0; bus.stb_n = 1'b1;
    repeat (6) cycle();
    cmp_model("m0_idle");

    // Mode 1 input: ibf exactly S+2 clocks after the stb fall, intr after the rise
    bus.inte = 1'b1;
    cfg(MODE1, DIR_IN);
    bus.port_in = 8'h3C;
    repeat (2) cycle();
    bus.stb_n = 1'b0;
    for (int i = 1; i <= S + 1; i++) begin
      cycle();
      chk1($sformatf("t2.ibf_early%0d", i), bus.ibf, 1'b0);
    end
    cycle();
    chk1("t2.ibf_set", bus.ibf, 1'b1);
    chk8("t2.rdata", bus.cpu_rdata, 8'h3C);
    chk1("t2.intr_before_rise", bus.intr, 1'b0);
    repeat (2) cycle();
    bus.stb_n = 1'b1; bus.port_in = 8'h00;
    repeat (S + 1) cycle();
    chk1("t2.intr_early", bus.intr, 1'b0);
    cycle();
    chk1("t2.intr_set", bus.intr, 1'b1);
    chk8("t2.rdata_held", bus.cpu_rdata, 8'h3C);
    bus.cpu_rd = 1'b1;
    cycle();
    bus.cpu_rd = 1'b0;
    chk1("t2.ibf_clr", bus.ibf, 1'b0);
    chk1("t2.intr_clr", bus.intr, 1'b0);
    chk8("t2.rdata_after_rd", bus.cpu_rdata, 8'h3C);

    // Mode 1 input: cpu_rd coincides with a new stb fall -> set wins, intr still cleared
    strobe(8'h12);
    chk1("t4.ibf_first", bus.ibf, 1'b1);
    chk1("t4.intr_first", bus.intr, 1'b1);
    bus.port_in = 8'h77; bus.stb_n = 1'b0;
    repeat (S + 1) cycle();
    bus.cpu_rd = 1'b1;
    cycle();
    bus.cpu_rd = 1'b0;
    chk1("t4.ibf_kept", bus.ibf, 1'b1);
    chk8("t4.rdata_new", bus.cpu_rdata, 8'h77);
    chk1("t4.intr_clr", bus.intr, 1'b0);
    bus.stb_n = 1'b1;
    repeat (6) cycle();
    cmp_model("t4_end");

    // Mode 1 output handshake
    cfg(MODE1, DIR_OUT);
    chk1("t3.obf_n_idle", bus.obf_n, 1'b1);
    chk1("t3.port_oe", bus.port_oe, 1'b1);
    bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'h5A;
    cycle();
    bus.cpu_wr = 1'b0;
    chk1("t3.obf_n_full", bus.obf_n, 1'b0);
    chk8("t3.port_out", bus.port_out, 8'h5A);
    chk8("t3.rdata", bus.cpu_rdata, 8'h5A);
    bus.ack_n = 1'b0;
    repeat (S + 1) cycle();
    chk1("t3.obf_n_early", bus.obf_n, 1'b0);
    cycle();
    chk1("t3.obf_n_ack", bus.obf_n, 1'b1);
    repeat (2) cycle();
    bus.ack_n = 1'b1;
    repeat (S + 1) cycle();
    chk1("t3.intr_early", bus.intr, 1'b0);
    cycle();
    chk1("t3.intr_set", bus.intr, 1'b1);
    bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'h11;
    cycle();
    bus.cpu_wr = 1'b0;
    chk1("t3.intr_clr", bus.intr, 1'b0);
    chk1("t3.obf_n_second", bus.obf_n, 1'b0);
    chk8("t3.port_out2", bus.port_out, 8'h11);

    // Mode 1 output with inte=0: request is held, intr appears when inte returns
    bus.inte = 1'b0;
    cfg(MODE1, DIR_OUT);
    bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'h42;
    cycle();
    bus.cpu_wr = 1'b0;
    bus.ack_n = 1'b0;
    repeat (6) cycle();
    bus.ack_n = 1'b1;
    repeat (6) cycle();
    chk1("t5.obf_n", bus.obf_n, 1'b1);
    chk1("t5.intr_masked", bus.intr, 1'b0);
    bus.inte = 1'b1;
    #1;
    chk1("t5.intr_unmasked", bus.intr, 1'b1);
    bus.inte = 1'b0;
    #1;
    chk1("t5.intr_remasked", bus.intr, 1'b0);
    bus.inte = 1'b1;

    // Asynchronous reset mid-handshake
    cfg(MODE1, DIR_IN);
    strobe(8'hAB);
    chk1("t6.ibf_pre", bus.ibf, 1'b1);
    chk1("t6.intr_pre", bus.intr, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("t6.ibf", bus.ibf, 1'b0);
    chk1("t6.intr", bus.intr, 1'b0);
    chk1("t6.obf_n", bus.obf_n, 1'b1);
    chk1("t6.port_oe", bus.port_oe, 1'b0);
    chk8("t6.port_out", bus.port_out, 8'h00);
    chk8("t6.rdata", bus.cpu_rdata, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1;
    cfg(MODE1, DIR_IN);
    repeat (8) cycle();
    chk1("t6.ibf_after", bus.ibf, 1'b0);
    chk1("t6.intr_after", bus.intr, 1'b0);
    cmp_model("t6_after");

    // Randomised traffic against the model
    for (int n = 0; n < 4000; n++) begin
      bus.cfg_wr  = ($urandom_range(0, 63) == 0);
      bus.mode_en = ($urandom_range(0, 3) != 0);
      bus.dir_in  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) bus.inte = ~bus.inte;
      bus.cpu_rd    = ($urandom_range(0, 7) == 0);
      bus.cpu_wr    = ($urandom_range(0, 7) == 0);
      bus.cpu_wdata = 8'($urandom);
      bus.port_in   = 8'($urandom);
      if ($urandom_range(0, 5) == 0) bus.stb_n = ~bus.stb_n;
      if ($urandom_range(0, 5) == 0) bus.ack_n = ~bus.ack_n;
      cycle();
      cmp_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
